// File: rtl/ni_pkg.sv
// ----------------------------------------------------------------------------
// ni_pkg
//   Shared types and constants for the neural_interface access arbiter.
//   - ni_state_e    : access sequencer states (IDLE/ISSUE/WAIT/RESP)
//   - NI_ADDR_W     : default neural_interface address width
//   - NI_DATA_W     : default neural_interface data width
//   - NI_RD_LAT_MAX : largest supported read latency (sizes the wait counter)
// ----------------------------------------------------------------------------
package ni_pkg;

  localparam int NI_ADDR_W     = 24;
  localparam int NI_DATA_W     = 64;
  localparam int NI_RD_LAT_MAX = 3;
  localparam int NI_CNT_W      = $clog2(NI_RD_LAT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } ni_state_e;

endpackage : ni_pkg

// File: rtl/ni_rr_arbiter.sv
// ----------------------------------------------------------------------------
// ni_rr_arbiter
//   Two-way request picker for the neural_interface access arbiter.
//   Holds the round-robin 'last' pointer (reset to 1 so port 0 wins the first
//   tie). With FIXED_PRIO != 0 port 1 wins every tie and 'last' is unused.
//
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     req[1:0]   : request vector {req1, req0}
//     update     : strobe; when high and any req is set, 'last' moves to
//                  the current winner
//     gnt[1:0]   : one-hot winner (combinational), 00 when no request
// ----------------------------------------------------------------------------
module ni_rr_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;
  logic win;

  always_comb begin
    // A lone requester always wins; a tie goes by policy.
    if (req == 2'b11) begin
      win = (FIXED_PRIO != 0) ? 1'b1 : ~last_q;
    end else begin
      win = req[1];
    end

    gnt = 2'b00;
    if (req != 2'b00) begin
      gnt = win ? 2'b10 : 2'b01;
    end

    last_d = last_q;
    if (update && (req != 2'b00)) begin
      last_d = win;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule : ni_rr_arbiter

// File: rtl/ni_access_arbiter.sv
// ----------------------------------------------------------------------------
// ni_access_arbiter
//   Shares the single neural_interface memory port between the Wishbone-side
//   requester (port 0) and the logic-analyser-side requester (port 1).
//   Each access is issued as a one-cycle command and completed with a
//   one-cycle ack pulse; read data is returned on rdata alongside the ack.
//
//   Parameters:
//     ADDR_W, DATA_W : neural_interface address / data widths
//     RD_LAT         : cycles from ni_addr presented to ni_rdata valid (0..3)
//     FIXED_PRIO     : 0 = round-robin, 1 = port 1 always wins a tie
//
//   Ports:
//     clk, rst_n                 : clock, asynchronous active-low reset
//     req0/1, we0/1              : request and direction, held until ack
//     addr0/1, wdata0/1          : access operands, latched at grant
//     ack0/1                     : one-cycle completion pulses
//     rdata                      : read data, valid while the ack is high
//     ni_addr, ni_wdata, ni_we   : registered command to neural_interface
//     ni_rdata                   : data_out from neural_interface
//     grant                      : one-hot owner of current access, 00 idle
//     busy                       : high whenever the sequencer is not idle
// ----------------------------------------------------------------------------
module ni_access_arbiter
  import ni_pkg::*;
#(
  parameter int ADDR_W     = NI_ADDR_W,
  parameter int DATA_W     = NI_DATA_W,
  parameter int RD_LAT     = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ni_addr,
  output logic [DATA_W-1:0] ni_wdata,
  output logic              ni_we,
  input  logic [DATA_W-1:0] ni_rdata,
  output logic [1:0]        grant,
  output logic              busy
);

  // WAIT runs RD_LAT-1 extra cycles after ISSUE, so the counter loads RD_LAT-1.
  localparam logic [NI_CNT_W-1:0] CNT_LOAD =
    (RD_LAT > 0) ? NI_CNT_W'(RD_LAT - 1) : '0;

  ni_state_e           state_q,    state_d;
  logic [NI_CNT_W-1:0] cnt_q,      cnt_d;
  logic                we_q,       we_d;
  logic [ADDR_W-1:0]   ni_addr_q,  ni_addr_d;
  logic [DATA_W-1:0]   ni_wdata_q, ni_wdata_d;
  logic                ni_we_q,    ni_we_d;
  logic [1:0]          grant_q,    grant_d;
  logic                ack0_q,     ack0_d;
  logic                ack1_q,     ack1_d;
  logic [DATA_W-1:0]   rdata_q,    rdata_d;
  logic                busy_q,     busy_d;

  logic [1:0] arb_gnt;
  logic       go_resp;

  // Requests are only looked at in IDLE, so 'last' only moves on a real grant.
  ni_rr_arbiter #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({req1, req0}),
    .update (state_q == IDLE),
    .gnt    (arb_gnt)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    ni_addr_d  = ni_addr_q;
    ni_wdata_d = ni_wdata_q;
    ni_we_d    = 1'b0;
    grant_d    = grant_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    rdata_d    = rdata_q;
    go_resp    = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_gnt != 2'b00) begin
          grant_d = arb_gnt;
          if (arb_gnt[1]) begin
            we_d       = we1;
            ni_addr_d  = addr1;
            ni_wdata_d = wdata1;
          end else begin
            we_d       = we0;
            ni_addr_d  = addr0;
            ni_wdata_d = wdata0;
          end
          // Registered here so the write strobe is high for the ISSUE cycle only.
          ni_we_d = we_d;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        if (we_q) begin
          go_resp = 1'b1;
        end else if (RD_LAT == 0) begin
          rdata_d = ni_rdata;
          go_resp = 1'b1;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = ni_rdata;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      RESP: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end

      default: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
    endcase

    // The ack is registered so it is high exactly during RESP.
    if (go_resp) begin
      ack0_d  = grant_q[0];
      ack1_d  = grant_q[1];
      state_d = RESP;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      ni_addr_q  <= '0;
      ni_wdata_q <= '0;
      ni_we_q    <= 1'b0;
      grant_q    <= 2'b00;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      ni_addr_q  <= ni_addr_d;
      ni_wdata_q <= ni_wdata_d;
      ni_we_q    <= ni_we_d;
      grant_q    <= grant_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rdata    = rdata_q;
  assign ni_addr  = ni_addr_q;
  assign ni_wdata = ni_wdata_q;
  assign ni_we    = ni_we_q;
  assign grant    = grant_q;
  assign busy     = busy_q;

endmodule : ni_access_arbiter

// File: tb/tb_ni_access_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ni_access_arbiter
//   Four arbiter instances with different configurations:
//     0: RD_LAT=1 round-robin   1: RD_LAT=3 round-robin
//     2: RD_LAT=0 round-robin   3: RD_LAT=1 port 1 fixed priority
//   Each instance sees its own neural_interface read model: a fixed address
//   to data function whose output is delayed by RD_LAT cycles behind ni_addr.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ni_access_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req0 [N];
  logic        req1 [N];
  logic        we0 [N];
  logic        we1 [N];
  logic [23:0] addr0 [N];
  logic [23:0] addr1 [N];
  logic [63:0] wdata0 [N];
  logic [63:0] wdata1 [N];
  logic        ack0 [N];
  logic        ack1 [N];
  logic [63:0] rdata [N];
  logic [23:0] ni_addr [N];
  logic [63:0] ni_wdata [N];
  logic        ni_we [N];
  logic [63:0] ni_rdata [N];
  logic [1:0]  grant [N];
  logic        busy [N];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: round-robin pointer and last read data per instance.
  logic        ref_last [N];
  logic [63:0] ref_rd [N];

  function automatic int lat_of(input int i);
    return (i == 1) ? 3 : (i == 2) ? 0 : 1;
  endfunction

  function automatic logic [63:0] rom(input logic [23:0] a);
    if (a == 24'h000020) return 64'h0000_0000_DEAD_BEEF;
    return {8'hC3, a, ~a, 8'h5A};
  endfunction

  for (genvar gi = 0; gi < N; gi++) begin : g
    localparam int L  = (gi == 1) ? 3 : (gi == 2) ? 0 : 1;
    localparam int FP = (gi == 3) ? 1 : 0;
    logic [23:0] apipe [4];

    ni_access_arbiter #(
      .ADDR_W     (24),
      .DATA_W     (64),
      .RD_LAT     (L),
      .FIXED_PRIO (FP)
    ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req0     (req0[gi]),
      .req1     (req1[gi]),
      .we0      (we0[gi]),
      .we1      (we1[gi]),
      .addr0    (addr0[gi]),
      .addr1    (addr1[gi]),
      .wdata0   (wdata0[gi]),
      .wdata1   (wdata1[gi]),
      .ack0     (ack0[gi]),
      .ack1     (ack1[gi]),
      .rdata    (rdata[gi]),
      .ni_addr  (ni_addr[gi]),
      .ni_wdata (ni_wdata[gi]),
      .ni_we    (ni_we[gi]),
      .ni_rdata (ni_rdata[gi]),
      .grant    (grant[gi]),
      .busy     (busy[gi])
    );

    always @(posedge clk) begin
      apipe[0] <= ni_addr[gi];
      for (int k = 1; k < 4; k++) apipe[k] <= apipe[k-1];
    end

    assign ni_rdata[gi] = rom((L == 0) ? ni_addr[gi] : apipe[(L == 0) ? 0 : L - 1]);
  end

  task automatic drive_port(input int i, input int p, input logic r, input logic w,
                            input logic [23:0] a, input logic [63:0] d);
    if (p == 0) begin
      req0[i] = r; we0[i] = w; addr0[i] = a; wdata0[i] = d;
    end else begin
      req1[i] = r; we1[i] = w; addr1[i] = a; wdata1[i] = d;
    end
  endtask

  task automatic test_reset();
    logic [157:0] obs;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      drive_port(i, 0, 1'b0, 1'b0, '0, '0);
      drive_port(i, 1, 1'b0, 1'b0, '0, '0);
      ref_last[i] = 1'b1;
      ref_rd[i]   = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      obs = {ack0[i], ack1[i], ni_we[i], busy[i], grant[i], ni_addr[i], ni_wdata[i], rdata[i]};
      n_checks++;
      if (obs !== '0)
        $display("FAIL reset_outputs[%0d]: got %h required 0", i, obs);
      if (obs !== '0) n_fail++;
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (busy[i] !== 1'b0 || grant[i] !== 2'b00) begin
        $display("FAIL idle_after_reset[%0d]: busy=%b grant=%b required 0/00", i, busy[i], grant[i]);
        n_fail++;
      end
    end
  endtask

  // One isolated access; checks the exact cycle of ni_we, ack and rdata.
  task automatic test_single(input int i, input int p, input logic w,
                             input logic [23:0] a, input logic [63:0] d, input string nm);
    int          lat;
    logic [63:0] exp_rd;
    logic        ackp, acko;
    lat    = w ? 2 : 2 + lat_of(i);
    exp_rd = w ? ref_rd[i] : rom(a);
    @(posedge clk); #1;
    drive_port(i, p, 1'b1, w, a, d);
    for (int c = 0; c <= lat + 2; c++) begin
      @(negedge clk);
      ackp = (p == 0) ? ack0[i] : ack1[i];
      acko = (p == 0) ? ack1[i] : ack0[i];
      n_checks++;
      if (ni_we[i] !== (w && c == 1)) begin
        $display("FAIL %s_ni_we c%0d: got %b required %b", nm, c, ni_we[i], (w && c == 1));
        n_fail++;
      end
      if (c == 1) begin
        n_checks++;
        if (ni_addr[i] !== a || (w && ni_wdata[i] !== d) || busy[i] !== 1'b1 ||
            grant[i] !== ((p == 0) ? 2'b01 : 2'b10)) begin
          $display("FAIL %s_issue: got addr=%h wdata=%h busy=%b grant=%b required addr=%h wdata=%h busy=1 port=%0d",
                   nm, ni_addr[i], ni_wdata[i], busy[i], grant[i], a, d, p);
          n_fail++;
        end
      end
      n_checks++;
      if (ackp !== (c == lat) || acko !== 1'b0) begin
        $display("FAIL %s_ack c%0d: got own=%b other=%b required own=%b other=0", nm, c, ackp, acko, (c == lat));
        n_fail++;
      end
      if (c == lat) begin
        n_checks++;
        if (rdata[i] !== exp_rd) begin
          $display("FAIL %s_rdata: got %h required %h", nm, rdata[i], exp_rd);
          n_fail++;
        end
      end
      if (c > lat) begin
        n_checks++;
        if (busy[i] !== 1'b0 || grant[i] !== 2'b00) begin
          $display("FAIL %s_idle c%0d: busy=%b grant=%b required 0/00", nm, c, busy[i], grant[i]);
          n_fail++;
        end
      end
      @(posedge clk); #1;
      if (c == lat) drive_port(i, p, 1'b0, w, a, d);
    end
    ref_last[i] = p[0];
    if (!w) ref_rd[i] = exp_rd;
  endtask

  // Both ports keep requesting reads; expected grant order from the policy.
  task automatic test_contention(input int i, input int n);
    int   exp_order[$];
    int   pend0, pend1, gidx, aidx, cyc, k0, k1, got;
    logic lastm, a0, a1;
    logic [1:0] prev_g;
    pend0 = n; pend1 = n; lastm = ref_last[i];
    while (pend0 > 0 || pend1 > 0) begin
      if (pend0 > 0 && pend1 > 0) got = (i == 3) ? 1 : (lastm ? 0 : 1);
      else got = (pend1 > 0) ? 1 : 0;
      exp_order.push_back(got);
      lastm = got[0];
      if (got == 1) pend1--; else pend0--;
    end
    gidx = 0; aidx = 0; cyc = 0; k0 = 0; k1 = 0; prev_g = 2'b00;
    @(posedge clk); #1;
    drive_port(i, 0, 1'b1, 1'b0, 24'h000100, '0);
    drive_port(i, 1, 1'b1, 1'b0, 24'h000200, '0);
    while (aidx < 2 * n && cyc < 60 * n) begin
      @(negedge clk);
      cyc++;
      if (grant[i] !== 2'b00 && prev_g === 2'b00) begin
        n_checks++;
        if (gidx >= 2 * n || grant[i] !== ((exp_order[gidx] == 1) ? 2'b10 : 2'b01)) begin
          $display("FAIL contention%0d_grant #%0d: got %b required port %0d", i, gidx, grant[i],
                   (gidx < 2 * n) ? exp_order[gidx] : -1);
          n_fail++;
        end
        gidx++;
      end
      prev_g = grant[i];
      a0 = ack0[i]; a1 = ack1[i];
      if (a0 || a1) begin
        got = a1 ? 1 : 0;
        n_checks++;
        if ((a0 && a1) || got != exp_order[aidx]) begin
          $display("FAIL contention%0d_ack #%0d: got ack0=%b ack1=%b required port %0d", i, aidx, a0, a1, exp_order[aidx]);
          n_fail++;
        end
        n_checks++;
        if (rdata[i] !== rom(a1 ? addr1[i] : addr0[i])) begin
          $display("FAIL contention%0d_rdata #%0d: got %h required %h", i, aidx, rdata[i], rom(a1 ? addr1[i] : addr0[i]));
          n_fail++;
        end
        aidx++;
      end
      @(posedge clk); #1;
      if (a0) begin
        k0++;
        drive_port(i, 0, (k0 < n), 1'b0, 24'(32'h100 + k0), '0);
      end
      if (a1) begin
        k1++;
        drive_port(i, 1, (k1 < n), 1'b0, 24'(32'h200 + k1), '0);
      end
    end
    n_checks++;
    if (aidx != 2 * n || gidx != 2 * n) begin
      $display("FAIL contention%0d_count: got acks=%0d grants=%0d required %0d", i, aidx, gidx, 2 * n);
      n_fail++;
      drive_port(i, 0, 1'b0, 1'b0, '0, '0);
      drive_port(i, 1, 1'b0, 1'b0, '0, '0);
    end
    ref_last[i] = lastm;
    ref_rd[i]   = rom((exp_order[2*n-1] == 1) ? 24'(32'h200 + n - 1) : 24'(32'h100 + n - 1));
  endtask

  task automatic test_back_to_back();
    int          we_cyc[$];
    int          nack;
    logic [23:0] a [2];
    logic [63:0] d [2];
    logic        acked;
    a[0] = 24'h000040; a[1] = 24'h000041;
    d[0] = {$urandom, $urandom}; d[1] = {$urandom, $urandom};
    nack = 0;
    @(posedge clk); #1;
    drive_port(0, 0, 1'b1, 1'b1, a[0], d[0]);
    for (int c = 0; c < 14 && nack < 2; c++) begin
      @(negedge clk);
      if (ni_we[0]) begin
        n_checks++;
        if (we_cyc.size() >= 2 || ni_addr[0] !== a[we_cyc.size() % 2] || ni_wdata[0] !== d[we_cyc.size() % 2]) begin
          $display("FAIL b2b_write #%0d: got addr=%h wdata=%h", we_cyc.size(), ni_addr[0], ni_wdata[0]);
          n_fail++;
        end
        we_cyc.push_back(c);
      end
      acked = ack0[0];
      if (acked) begin
        n_checks++;
        if (rdata[0] !== ref_rd[0]) begin
          $display("FAIL b2b_rdata_hold: got %h required %h", rdata[0], ref_rd[0]);
          n_fail++;
        end
        nack++;
      end
      @(posedge clk); #1;
      if (acked) drive_port(0, 0, (nack < 2), 1'b1, a[1], d[1]);
    end
    n_checks++;
    if (we_cyc.size() != 2 || nack != 2) begin
      $display("FAIL b2b_count: got writes=%0d acks=%0d required 2/2", we_cyc.size(), nack);
      n_fail++;
      drive_port(0, 0, 1'b0, 1'b0, '0, '0);
    end else begin
      n_checks++;
      if (we_cyc[0] != 1 || we_cyc[1] - we_cyc[0] != 3) begin
        $display("FAIL b2b_spacing: got cycles %0d,%0d required 1,4", we_cyc[0], we_cyc[1]);
        n_fail++;
      end
    end
    ref_last[0] = 1'b0;
  endtask

  task automatic test_rd_lat0_sweep();
    logic [23:0] a;
    for (int k = 0; k < 4; k++) begin
      a = 24'($urandom_range(0, 32'hFF_FFFE));
      test_single(2, k % 2, 1'b0, a, '0, "rdlat0");
    end
    test_single(2, 0, 1'b1, 24'h000077, 64'h0123_4567_89AB_CDEF, "rdlat0_wr");
  endtask

  // Random reads/writes with random gaps; ports use disjoint address halves.
  task automatic test_random(input int i, input int n);
    logic        opw [2][16];
    logic [23:0] opa [2][16];
    logic [63:0] opd [2][16];
    int          k [2];
    int          gap [2];
    logic        done [2];
    logic [63:0] exp;
    int          nwr_exp, nwe, cyc, p;
    logic        rq;
    nwr_exp = 0; nwe = 0; cyc = 0;
    for (int q = 0; q < 2; q++) begin
      k[q] = 0;
      gap[q] = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) begin
        opw[q][j] = 1'($urandom_range(0, 1));
        opa[q][j] = {q[0], 23'($urandom)};
        opd[q][j] = {$urandom, $urandom};
        if (opw[q][j]) nwr_exp++;
      end
    end
    while ((k[0] < n || k[1] < n) && cyc < 100 * n) begin
      @(negedge clk);
      cyc++;
      done[0] = 1'b0; done[1] = 1'b0;
      if (ni_we[i]) begin
        p = grant[i][1] ? 1 : 0;
        nwe++;
        n_checks++;
        if ((grant[i] !== 2'b01 && grant[i] !== 2'b10) || k[p] >= n || !opw[p][k[p] % 16] ||
            ni_addr[i] !== opa[p][k[p] % 16] || ni_wdata[i] !== opd[p][k[p] % 16]) begin
          $display("FAIL rand%0d_write: got grant=%b addr=%h wdata=%h", i, grant[i], ni_addr[i], ni_wdata[i]);
          n_fail++;
        end
      end
      if (ack0[i] || ack1[i]) begin
        p = ack1[i] ? 1 : 0;
        rq = (p == 0) ? req0[i] : req1[i];
        n_checks++;
        if ((ack0[i] && ack1[i]) || k[p] >= n || rq !== 1'b1) begin
          $display("FAIL rand%0d_ack: got ack0=%b ack1=%b req=%b required a single ack to a requester", i, ack0[i], ack1[i], rq);
          n_fail++;
        end else begin
          exp = opw[p][k[p]] ? ref_rd[i] : rom(opa[p][k[p]]);
          n_checks++;
          if (rdata[i] !== exp) begin
            $display("FAIL rand%0d_rdata port%0d op%0d: got %h required %h", i, p, k[p], rdata[i], exp);
            n_fail++;
          end
          ref_rd[i] = exp;
        end
        done[p] = 1'b1;
      end
      @(posedge clk); #1;
      for (int q = 0; q < 2; q++) begin
        if (done[q]) begin
          k[q]++;
          gap[q] = $urandom_range(0, 2);
          drive_port(i, q, 1'b0, 1'b0, '0, '0);
        end
        rq = (q == 0) ? req0[i] : req1[i];
        if (!rq && k[q] < n) begin
          if (gap[q] == 0) drive_port(i, q, 1'b1, opw[q][k[q]], opa[q][k[q]], opd[q][k[q]]);
          else gap[q]--;
        end
      end
    end
    n_checks++;
    if (k[0] < n || k[1] < n || nwe != nwr_exp) begin
      $display("FAIL rand%0d_complete: got done=%0d/%0d writes=%0d required %0d/%0d writes=%0d",
               i, k[0], k[1], nwe, n, n, nwr_exp);
      n_fail++;
      drive_port(i, 0, 1'b0, 1'b0, '0, '0);
      drive_port(i, 1, 1'b0, 1'b0, '0, '0);
    end
  endtask

  // Instance 1 is in WAIT of a read and instance 0 is issuing a write when
  // reset is asserted between clock edges.
  task automatic test_reset_mid_access();
    @(posedge clk); #1;
    drive_port(1, 0, 1'b1, 1'b0, 24'h000333, '0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      @(posedge clk); #1;
      if (c == 1) drive_port(0, 1, 1'b1, 1'b1, 24'h000444, 64'hFACE_0000_CAFE_0001);
    end
    @(negedge clk);
    n_checks++;
    if (busy[1] !== 1'b1 || grant[1] !== 2'b01 || ni_we[0] !== 1'b1 || grant[0] !== 2'b10) begin
      $display("FAIL rst_pre: got busy1=%b grant1=%b ni_we0=%b grant0=%b required 1/01/1/10",
               busy[1], grant[1], ni_we[0], grant[0]);
      n_fail++;
    end
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (busy[i] !== 1'b0 || grant[i] !== 2'b00 || ni_we[i] !== 1'b0 || ack0[i] !== 1'b0 || ack1[i] !== 1'b0) begin
        $display("FAIL rst_async[%0d]: got busy=%b grant=%b ni_we=%b ack=%b%b required all 0",
                 i, busy[i], grant[i], ni_we[i], ack1[i], ack0[i]);
        n_fail++;
      end
    end
    drive_port(1, 0, 1'b0, 1'b0, '0, '0);
    drive_port(0, 1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      ref_last[i] = 1'b1;
      ref_rd[i]   = '0;
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_checks++;
      if (ack0[0] || ack1[0] || ack0[1] || ack1[1] || busy[0] || busy[1]) begin
        $display("FAIL rst_no_ack c%0d: got ack/busy activity after reset, required none", c);
        n_fail++;
      end
    end
    n_checks++;
    if (rdata[1] !== '0) begin
      $display("FAIL rst_rdata: got %h required 0", rdata[1]);
      n_fail++;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single(0, 0, 1'b1, 24'h000010, 64'h1234, "single_wr");
    test_single(0, 1, 1'b0, 24'h000020, '0, "single_rd");
    test_contention(0, 6);
    test_contention(3, 6);
    test_back_to_back();
    test_rd_lat0_sweep();
    test_single(1, 1, 1'b0, 24'h000020, '0, "rdlat3_rd");
    test_single(1, 0, 1'b1, 24'h000021, 64'h5555_AAAA_5555_AAAA, "rdlat3_wr");
    test_random(0, 12);
    test_random(1, 12);
    test_reset_mid_access();
    test_single(1, 0, 1'b0, 24'h000334, '0, "post_reset_rd");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ni_access_arbiter

// File: doc/ni_access_arbiter.md
# ni_access_arbiter

Two-port arbiter and access sequencer for the `neural_interface` weight/activation memory. It shares the single `addr`/`data_in`/`we`/`data_out` port between two requesters: port 0 is the Wishbone-side path and port 1 is the logic-analyser-side path. Each access is issued as a clean one-cycle command, and read data is returned through a req/ack handshake. It sits between the top-level bus glue and `neural_interface`, replacing the current combinational mux and its direct `we` OR.

## Interface
Parameters:
- `ADDR_W`, 24, neural_interface address width
- `DATA_W`, 64, neural_interface data width
- `RD_LAT`, 1, cycles from `ni_addr` presented to `ni_rdata` valid; legal range 0..3
- `FIXED_PRIO`, 0, selects the arbitration policy: 0 = round-robin, 1 = port 1 always wins

Ports:
- `clk`, input, 1, single clock for the whole block
- `rst_n`, input, 1, asynchronous active-low reset
- `req0` / `req1`, input, 1, access request; held with operands until ack
- `we0` / `we1`, input, 1, write (1) / read (0)
- `addr0` / `addr1`, input, ADDR_W, access address
- `wdata0` / `wdata1`, input, DATA_W, write data
- `ack0` / `ack1`, output, 1, one-cycle completion pulse
- `rdata`, output, DATA_W, read data; valid while the matching ack is high
- `ni_addr`, output, ADDR_W, to neural_interface `addr`
- `ni_wdata`, output, DATA_W, to neural_interface `data_in`
- `ni_we`, output, 1, to neural_interface `we`; one-cycle pulse
- `ni_rdata`, input, DATA_W, from neural_interface `data_out`
- `grant`, output, 2, one-hot owner of the current access; 00 when idle
- `busy`, output, 1, high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - If any req is high, pick a winner, latch its we/addr/wdata into the ni_* registers, set `grant`, and go to ISSUE.
  - If no req is high, stay in IDLE.
- **Arbitration:**
  - Round-robin uses a `last` pointer; reset value is 1, so port 0 wins the first tie.
  - `last` updates to the winner on each grant.
  - With `FIXED_PRIO`=1, port 1 wins every tie.
- **ISSUE:**
  - `ni_we` equals the latched we for exactly this cycle.
  - On a write, go to RESP.
  - On a read with RD_LAT=0, capture `ni_rdata` into `rdata` and go to RESP.
  - On a read with RD_LAT>0, load `cnt`=RD_LAT-1 and go to WAIT.
- **WAIT:**
  - Decrement `cnt` each cycle.
  - When `cnt`==0, capture `ni_rdata` into `rdata` and go to RESP.
- **RESP:**
  - Pulse the winner's ack for one cycle, then go to IDLE.
  - `grant` clears on entering IDLE.
  - `ni_addr` and `ni_wdata` hold their last values.
- **Requester rule:**
  - req must drop on the edge at which ack is sampled high.
  - IDLE re-samples req in the cycle after RESP, so back-to-back accesses from one port are legal.
- **Request handling:**
  - Requests are never queued: a losing port simply keeps req high.
  - req changes outside IDLE are ignored.
  - Operand changes after grant are ignored, because operands are latched.
- **rdata:**
  - Updated only on reads; it holds its value across writes.
  - Writes ack with rdata unchanged.

## Timing
- **Reset values:**
  - All outputs are 0: ack0, ack1, rdata, ni_addr, ni_wdata, ni_we, grant, busy.
  - State is IDLE and `last` is 1.
- **Latency**, with req first seen high in IDLE at cycle 0:
  - Write: ni_we high in cycle 1, ack in cycle 2.
  - Read: ni_addr valid from cycle 1, ack in cycle 2+RD_LAT.
- **Throughput:** one access per 3 cycles for writes, and 3+RD_LAT cycles for reads.
- **Starvation bound (round-robin):** with both ports continuously requesting, grants alternate 0,1,0,1. A waiting port is served within one foreign access.
- **Reset mid-access:**
  - State returns to IDLE immediately and asynchronously.
  - ni_we drops without waiting for an edge; no ack is issued for the aborted access.
  - The requester retries after reset.
- **Simultaneous req0 and req1:** exactly one grant, per policy; the loser's ack stays low.
- **Output registration:** all outputs are registered, with no combinational path from req/addr to ni_*.

## Structure
- Package `ni_pkg` holds:
  - the state enum (IDLE/ISSUE/WAIT/RESP);
  - ADDR_W/DATA_W defaults;
  - the `NI_RD_LAT_MAX`=3 constant.
- Sub-module `ni_rr_arbiter`: 2-way picker containing the `last` register, the FIXED_PRIO mux and an `update` strobe.
- The FSM, operand latches, `cnt` and the ack/rdata registers live in the top module.

## Test plan
- **Single write:** req0=1, we0=1, addr0=0x000010, wdata0=0x1234 -> ni_we high cycle 1 only with ni_addr=0x000010 and ni_wdata=0x1234; ack0 high cycle 2; ack1 never high.
- **Single read, RD_LAT=1:** model returns 0xDEADBEEF for addr1=0x000020 -> ack1 in cycle 3 with rdata=0xDEADBEEF; ni_we stays 0.
- **Contention:** req0 and req1 held continuously with 6 reads each -> grant sequence 01,10,01,... and all 12 acks in order. With FIXED_PRIO=1, all port-1 accesses complete before any port-0 access.
- **Back-to-back writes from port 0:** req re-asserted in the cycle after ack -> second ni_we exactly 3 cycles after the first.
- **Reset mid-read:** rst_n pulled low in WAIT (RD_LAT=3) -> busy, grant and ni_we go to 0 before the next edge; no ack; after release, the first request to port 0 completes normally.
- **RD_LAT=0 sweep:** read ack in cycle 2 with rdata equal to the combinational model value.
